// File: rtl/wire_route_reg.sv
// wire_route_reg: registered NUM_IN->NUM_OUT lane router with a runtime select/enable table
//   clk, rst       clock, asynchronous active-high reset
//   in_valid       input sample strobe
//   in_data        NUM_IN lanes of WIDTH bits, lane i at [i*WIDTH +: WIDTH]
//   cfg_we         config write strobe for entry cfg_idx (cfg_sel, cfg_en)
//   out_valid      out_data carries a new sample this cycle
//   out_data       NUM_OUT lanes of WIDTH bits, lane j at [j*WIDTH +: WIDTH]
//   cfg_err        one-cycle pulse after a rejected config write
module wire_route_reg #(
   parameter int WIDTH = 1,
   parameter int NUM_IN = 3,
   parameter int NUM_OUT = 4,
   localparam int SEL_W = NUM_IN > 1 ? $clog2(NUM_IN) : 1,
   localparam int IDX_W = NUM_OUT > 1 ? $clog2(NUM_OUT) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [NUM_IN*WIDTH-1:0]    in_data,
   input  logic                       cfg_we,
   input  logic [IDX_W-1:0]           cfg_idx,
   input  logic [SEL_W-1:0]           cfg_sel,
   input  logic                       cfg_en,
   output logic                       out_valid,
   output logic [NUM_OUT*WIDTH-1:0]   out_data,
   output logic                       cfg_err
);
   // lane array padded to the full select range so any sel value indexes a real entry
   logic [WIDTH-1:0] lane [2**SEL_W];
   logic [SEL_W-1:0] sel [NUM_OUT];
   logic             en [NUM_OUT];
   logic             cfg_ok;

   for (genvar i = 0; i < 2**SEL_W; i++) begin : g_lane
      if (i < NUM_IN) begin : g_real
         assign lane[i] = in_data[i*WIDTH +: WIDTH];
      end else begin : g_pad
         assign lane[i] = '0;
      end
   end

   assign cfg_ok = 32'(cfg_idx) < NUM_OUT && 32'(cfg_sel) < NUM_IN;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 0; j < NUM_OUT; j++) begin
            sel[j] <= SEL_W'(j % NUM_IN);
            en[j] <= 1'b1;
         end
         out_data <= '0;
         out_valid <= 1'b0;
         cfg_err <= 1'b0;
      end else begin
         // datapath reads the table before this edge's write lands
         if (in_valid)
            for (int j = 0; j < NUM_OUT; j++)
               out_data[j*WIDTH +: WIDTH] <= en[j] ? lane[sel[j]] : '0;
         for (int j = 0; j < NUM_OUT; j++)
            if (cfg_we && cfg_ok && 32'(cfg_idx) == j) begin
               sel[j] <= cfg_sel;
               en[j] <= cfg_en;
            end
         out_valid <= in_valid;
         cfg_err <= cfg_we && !cfg_ok;
      end
   end
endmodule

// File: tb/tb_wire_route_reg.sv
// tb_wire_route_reg: directed self-checking bench for wire_route_reg (default parameters)
module tb_wire_route_reg;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [2:0] in_data = '0;
   logic       cfg_we = 1'b0;
   logic [1:0] cfg_idx = '0;
   logic [1:0] cfg_sel = '0;
   logic       cfg_en = 1'b0;
   logic       out_valid;
   logic [3:0] out_data;
   logic       cfg_err;
   int         n_chk = 0;
   int         n_fail = 0;

   wire_route_reg dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sel(cfg_sel), .cfg_en(cfg_en),
      .out_valid(out_valid), .out_data(out_data), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic sample(input logic [2:0] d);
      in_valid = 1'b1;
      in_data = d;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wr(input logic [1:0] idx, input logic [1:0] s, input logic e);
      cfg_we = 1'b1;
      cfg_idx = idx;
      cfg_sel = s;
      cfg_en = e;
      tick();
      cfg_we = 1'b0;
   endtask

   initial begin
      tick();
      check("rst_valid", 32'(out_valid), 0);
      check("rst_data", 32'(out_data), 0);
      check("rst_err", 32'(cfg_err), 0);
      rst = 1'b0;
      sample(3'b101);
      check("dflt_valid", 32'(out_valid), 1);
      check("dflt_data", 32'(out_data), 32'b1101);
      wr(2'd2, 2'd1, 1'b1);
      check("wr_ok_err", 32'(cfg_err), 0);
      wr(2'd3, 2'd2, 1'b1);
      in_valid = 1'b1;
      in_data = 3'b010;
      tick();
      check("remap_a", 32'(out_data), 32'b0110);
      in_data = 3'b101;
      tick();
      check("b2b_valid", 32'(out_valid), 1);
      check("remap_b", 32'(out_data), 32'b1001);
      in_valid = 1'b0;
      tick();
      check("idle_valid", 32'(out_valid), 0);
      check("idle_hold", 32'(out_data), 32'b1001);
      wr(2'd2, 2'd1, 1'b0);
      sample(3'b111);
      check("disable", 32'(out_data), 32'b1011);
      wr(2'd0, 2'd3, 1'b1);
      check("err_pulse", 32'(cfg_err), 1);
      tick();
      check("err_clear", 32'(cfg_err), 0);
      sample(3'b111);
      check("err_nochg", 32'(out_data), 32'b1011);
      cfg_we = 1'b1;
      cfg_idx = 2'd0;
      cfg_sel = 2'd2;
      cfg_en = 1'b1;
      in_valid = 1'b1;
      in_data = 3'b100;
      tick();
      cfg_we = 1'b0;
      in_valid = 1'b0;
      check("same_old", 32'(out_data), 32'b1000);
      sample(3'b100);
      check("same_new", 32'(out_data), 32'b1001);
      sample(3'b010);
      check("gap1_valid", 32'(out_valid), 1);
      check("gap1_data", 32'(out_data), 32'b0010);
      tick();
      check("gap_valid", 32'(out_valid), 0);
      check("gap_hold", 32'(out_data), 32'b0010);
      sample(3'b111);
      check("gap2_valid", 32'(out_valid), 1);
      check("gap2_data", 32'(out_data), 32'b1011);
      #2 rst = 1'b1;
      #1;
      check("arst_valid", 32'(out_valid), 0);
      check("arst_data", 32'(out_data), 0);
      #2 rst = 1'b0;
      sample(3'b101);
      check("post_valid", 32'(out_valid), 1);
      check("post_data", 32'(out_data), 32'b1101);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
